// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared FSM states, word flags and colour-bar table for the camera packer
package cam_pkg;

    typedef enum logic [1:0] {
        S_WAIT_FRAME = 2'd0,
        S_WAIT_LINE  = 2'd1,
        S_ACTIVE     = 2'd2,
        S_PAD        = 2'd3
    } t_cam_state;

    localparam logic [1:0] c_flag_frame = 2'b11;
    localparam logic [1:0] c_flag_line  = 2'b01;
    localparam logic [1:0] c_flag_none  = 2'b00;

    // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][15:0] c_bar_rgb565 = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

endpackage

// File: rtl/pix_out_buf.sv
// rtl/pix_out_buf.sv - 2-entry valid/ready word buffer with registered head and full flag
module pix_out_buf #(
    parameter int p_width = 18
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [p_width-1:0] i_data,
    output logic               o_full,
    output logic               o_valid,
    output logic [p_width-1:0] o_data,
    input  logic               i_ready
);

    logic [p_width-1:0] head_q, head_d;
    logic [p_width-1:0] tail_q, tail_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               pop;
    logic               push;

    // Next-state for head/tail/count; a push into a full buffer is only taken alongside a pop
    always_comb begin
        pop    = (cnt_q != 2'd0) && i_ready;
        push   = i_valid && ((cnt_q != 2'd2) || pop);
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = i_data;
                end else begin
                    tail_d = i_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = i_data;
                end else begin
                    head_d = tail_q;
                    tail_d = i_data;
                end
            end
            default: begin
            end
        endcase
    end

    // Storage registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_valid = (cnt_q != 2'd0);
    assign o_full  = (cnt_q == 2'd2);
    assign o_data  = head_q;

endmodule

// File: rtl/cam_pixel_packer.sv
// rtl/cam_pixel_packer.sv - DVP byte stream to flagged RGB565 words; CAM_TEST_PATTERN_EN adds a colour-bar source
module cam_pixel_packer
    import cam_pkg::*;
#(
    parameter int p_dram_dataw = 16,
    parameter int p_cols       = 640,
    parameter int p_rows       = 480,
    parameter int p_byte_swap  = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_vsync,
    input  logic                      i_href,
    input  logic [7:0]                i_data,
`ifdef CAM_TEST_PATTERN_EN
    input  logic                      i_pattern_sel,
`endif
    output logic                      o_valid,
    output logic [p_dram_dataw+1:0]   o_data,
    input  logic                      i_ready,
    output logic                      o_frame_done,
    output logic                      o_overflow,
    output logic [15:0]               o_drop_count,
    output logic [$clog2(p_rows):0]   o_line_count
);

    localparam int c_cw = $clog2(p_cols + 1);
    localparam int c_rw = $clog2(p_rows) + 1;
    localparam logic [c_cw-1:0] c_cols = c_cw'(p_cols);
    localparam logic [c_rw-1:0] c_rows = c_rw'(p_rows);

    logic                    vs_q, vs_d1_q, hr_q, hr_d1_q;
    logic [7:0]              dat_q;
    logic                    vs_rise, vs_fall, hr_rise, hr_fall;

    t_cam_state              state_q, state_d;
    logic [c_rw-1:0]         row_q, row_d;
    logic [c_rw-1:0]         lc_q, lc_d;
    logic [c_cw-1:0]         col_q, col_d;
    logic                    phase_q, phase_d;
    logic [7:0]              lat_q, lat_d;
    logic                    end_line;
    logic [15:0]             cam_word;

    logic                    prod_q, prod_d;
    logic [p_dram_dataw-1:0] pix_d;
    logic [1:0]              flag_d;
    logic [p_dram_dataw+1:0] prod_data_q;
    logic                    fdone_q, fdone_d;

    logic                    buf_full, buf_valid;
    logic                    drop;
    logic                    ovf_q;
    logic [15:0]             drop_cnt_q;

`ifdef CAM_TEST_PATTERN_EN
    logic [2:0]              bar;
`endif

    // Camera inputs registered once, plus a delayed copy for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vs_q    <= 1'b0;
            vs_d1_q <= 1'b0;
            hr_q    <= 1'b0;
            hr_d1_q <= 1'b0;
            dat_q   <= 8'd0;
        end else begin
            vs_q    <= i_vsync;
            vs_d1_q <= vs_q;
            hr_q    <= i_href;
            hr_d1_q <= hr_q;
            dat_q   <= i_data;
        end
    end

    assign vs_rise  = vs_q & ~vs_d1_q;
    assign vs_fall  = ~vs_q & vs_d1_q;
    assign hr_rise  = hr_q & ~hr_d1_q;
    assign hr_fall  = ~hr_q & hr_d1_q;
    assign cam_word = (p_byte_swap != 0) ? {dat_q, lat_q} : {lat_q, dat_q};

`ifdef CAM_TEST_PATTERN_EN
    assign bar = 3'((32'(col_q) * 32'd8) / 32'(p_cols));
`endif

    // Frame/line FSM: byte pairing, column/row geometry, padding and word production
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        lc_d     = lc_q;
        col_d    = col_q;
        phase_d  = phase_q;
        lat_d    = lat_q;
        prod_d   = 1'b0;
        pix_d    = '0;
        fdone_d  = 1'b0;
        end_line = 1'b0;

        if (vs_rise && (state_q != S_WAIT_FRAME)) begin
            state_d = S_WAIT_FRAME;
        end else begin
            case (state_q)
                S_WAIT_FRAME: begin
                    if (vs_fall) begin
                        row_d   = '0;
                        col_d   = '0;
                        lc_d    = '0;
                        phase_d = 1'b0;
                        state_d = S_WAIT_LINE;
                    end
                end
                S_WAIT_LINE: begin
                    // The rising-edge cycle already carries the first byte of the line
                    if (hr_rise && (row_q != c_rows)) begin
                        col_d   = '0;
                        lat_d   = dat_q;
                        phase_d = 1'b1;
                        state_d = S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (hr_fall) begin
                        phase_d = 1'b0;
                        if (col_q < c_cols) begin
                            state_d = S_PAD;
                        end else begin
                            end_line = 1'b1;
                        end
                    end else if (hr_q) begin
                        if (!phase_q) begin
                            lat_d   = dat_q;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (col_q < c_cols) begin
                                prod_d = 1'b1;
                                pix_d  = p_dram_dataw'(cam_word);
                                col_d  = col_q + 1'b1;
                            end
                        end
                    end
                end
                S_PAD: begin
                    if (col_q < c_cols) begin
                        prod_d = 1'b1;
                        col_d  = col_q + 1'b1;
                        if ((col_q + 1'b1) == c_cols) begin
                            end_line = 1'b1;
                        end
                    end else begin
                        end_line = 1'b1;
                    end
                end
                default: begin
                    state_d = S_WAIT_FRAME;
                end
            endcase

            if (end_line) begin
                row_d = row_q + 1'b1;
                lc_d  = row_q + 1'b1;
                if ((row_q + 1'b1) == c_rows) begin
                    fdone_d = 1'b1;
                    state_d = S_WAIT_FRAME;
                end else begin
                    state_d = S_WAIT_LINE;
                end
            end
        end

`ifdef CAM_TEST_PATTERN_EN
        if (prod_d && i_pattern_sel) begin
            pix_d = p_dram_dataw'(c_bar_rgb565[bar]);
        end
`endif

        // Flags are positional, so they apply to pad words at col 0 as well
        if (col_q == '0) begin
            flag_d = (row_q == '0) ? c_flag_frame : c_flag_line;
        end else begin
            flag_d = c_flag_none;
        end
    end

    // FSM state and the pack-stage word register feeding the output buffer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_WAIT_FRAME;
            row_q       <= '0;
            lc_q        <= '0;
            col_q       <= '0;
            phase_q     <= 1'b0;
            lat_q       <= 8'd0;
            prod_q      <= 1'b0;
            prod_data_q <= '0;
            fdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            lc_q        <= lc_d;
            col_q       <= col_d;
            phase_q     <= phase_d;
            lat_q       <= lat_d;
            prod_q      <= prod_d;
            prod_data_q <= {pix_d, flag_d};
            fdone_q     <= fdone_d;
        end
    end

    pix_out_buf #(
        .p_width (p_dram_dataw + 2)
    ) u_out_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (prod_q),
        .i_data  (prod_data_q),
        .o_full  (buf_full),
        .o_valid (buf_valid),
        .o_data  (o_data),
        .i_ready (i_ready)
    );

    assign drop = prod_q && buf_full && !(buf_valid && i_ready);

    // Sticky overflow and saturating drop counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= 16'd0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign o_valid      = buf_valid;
    assign o_frame_done = fdone_q;
    assign o_overflow   = ovf_q;
    assign o_drop_count = drop_cnt_q;
    assign o_line_count = lc_q;

endmodule

// File: tb/tb_cam_pixel_packer.sv
// tb/tb_cam_pixel_packer.sv - self-checking bench for cam_pixel_packer
module tb_cam_pixel_packer;

    localparam int COLS = 16;
    localparam int ROWS = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_vsync = 1'b0;
    logic        i_href = 1'b0;
    logic [7:0]  i_data = 8'd0;
    logic        i_ready = 1'b1;
    logic        o_valid;
    logic [17:0] o_data;
    logic        o_frame_done;
    logic        o_overflow;
    logic [15:0] o_drop_count;
    logic [2:0]  o_line_count;

    cam_pixel_packer #(
        .p_dram_dataw (16),
        .p_cols       (COLS),
        .p_rows       (ROWS),
        .p_byte_swap  (0)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_vsync      (i_vsync),
        .i_href       (i_href),
        .i_data       (i_data),
`ifdef CAM_TEST_PATTERN_EN
        .i_pattern_sel(1'b0),
`endif
        .o_valid      (o_valid),
        .o_data       (o_data),
        .i_ready      (i_ready),
        .o_frame_done (o_frame_done),
        .o_overflow   (o_overflow),
        .o_drop_count (o_drop_count),
        .o_line_count (o_line_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int nbytes;
        bit ready;
        int exp_lc;
        int exp_drops;
        bit exp_ovf;
    } line_vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];
    logic [7:0]  line_bytes[64];
    bit          mon_en = 1'b1;
    int          fd_cnt = 0;
    int          out_cnt = 0;

    // Observe accepted words and frame-done cycles
    always @(negedge i_clk) begin
        if (o_frame_done) fd_cnt++;
        if (o_valid && i_ready) begin
            out_cnt++;
            if (mon_en) obs_q.push_back(o_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic drain_obs();
        logic [17:0] w;
        while (obs_q.size() > 0) begin
            w = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(w), 32'h3FFFF);
            end else begin
                chk("word", 32'(w), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic fill_bytes(input int n);
        for (int i = 0; i < n; i++) line_bytes[i] = 8'($urandom_range(0, 255));
    endtask

    // Reference line: pairs high byte first, zero pad up to COLS, positional flags
    task automatic push_exp(input int n, input int row, input int keep);
        logic [15:0] pix;
        logic [1:0]  flg;
        for (int k = 0; k < COLS; k++) begin
            pix = (2 * k + 1 < n) ? {line_bytes[2*k], line_bytes[2*k+1]} : 16'h0000;
            if (k == 0) flg = (row == 0) ? 2'b11 : 2'b01;
            else        flg = 2'b00;
            if (k < keep) exp_q.push_back({pix, flg});
        end
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) begin
            i_href = 1'b1;
            i_data = line_bytes[i];
            tick(1);
        end
        i_href = 1'b0;
        i_data = 8'd0;
        tick(30);
    endtask

    task automatic vsync_pulse();
        i_vsync = 1'b1;
        tick(4);
        i_vsync = 1'b0;
        tick(4);
    endtask

    line_vec_t tbl[8];
    int        lat;
    int        snap;

    initial begin
        tbl[0] = '{32, 1'b1, 1, 0, 1'b0};
        tbl[1] = '{32, 1'b1, 2, 0, 1'b0};
        tbl[2] = '{32, 1'b1, 3, 0, 1'b0};
        tbl[3] = '{32, 1'b1, 4, 0, 1'b0};
        tbl[4] = '{32, 1'b1, 1, 0, 1'b0};
        tbl[5] = '{20, 1'b1, 2, 0, 1'b0};
        tbl[6] = '{41, 1'b1, 3, 0, 1'b0};
        tbl[7] = '{32, 1'b0, 4, 14, 1'b1};

        tick(5);
        i_rst = 1'b0;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_frame_done", 32'(o_frame_done), 0);
        chk("rst_overflow", 32'(o_overflow), 0);
        chk("rst_drop_count", 32'(o_drop_count), 0);
        chk("rst_line_count", 32'(o_line_count), 0);
        tick(3);

        // Two frames: nominal, then short / long+odd / backpressured lines
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 0) vsync_pulse();
            i_ready = tbl[i].ready;
            fill_bytes(tbl[i].nbytes);
            push_exp(tbl[i].nbytes, i % 4, tbl[i].ready ? COLS : 2);
            send_line(tbl[i].nbytes);
            drain_obs();
            chk("line_count", 32'(o_line_count), 32'(tbl[i].exp_lc));
            chk("drop_count", 32'(o_drop_count), 32'(tbl[i].exp_drops));
            chk("overflow", 32'(o_overflow), 32'(tbl[i].exp_ovf));
            if (i % 4 == 3) chk("frame_done_pulses", 32'(fd_cnt), 32'(i / 4 + 1));
        end
        i_ready = 1'b1;
        tick(10);
        drain_obs();
        chk("backpressure_drained", 32'(exp_q.size()), 0);

        // Abort after row 1: no frame_done, line count holds, next frame restarts at flag 11
        vsync_pulse();
        for (int r = 0; r < 2; r++) begin
            fill_bytes(32);
            push_exp(32, r, COLS);
            send_line(32);
        end
        i_vsync = 1'b1;
        tick(6);
        chk("abort_line_count", 32'(o_line_count), 2);
        snap = out_cnt;
        fill_bytes(32);
        send_line(32);
        chk("abort_no_output", 32'(out_cnt - snap), 0);
        chk("abort_no_frame_done", 32'(fd_cnt), 2);
        chk("abort_overflow_sticky", 32'(o_overflow), 1);
        i_vsync = 1'b0;
        tick(4);
        fill_bytes(32);
        push_exp(32, 0, COLS);
        send_line(32);
        drain_obs();
        chk("restart_line_count", 32'(o_line_count), 1);
        chk("restart_drained", 32'(exp_q.size()), 0);

        // Reset in the middle of a line
        vsync_pulse();
        mon_en = 1'b0;
        fill_bytes(10);
        for (int i = 0; i < 10; i++) begin
            i_href = 1'b1;
            i_data = line_bytes[i];
            tick(1);
        end
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        i_href = 1'b0;
        chk("mid_rst_valid", 32'(o_valid), 0);
        chk("mid_rst_data", 32'(o_data), 0);
        chk("mid_rst_frame_done", 32'(o_frame_done), 0);
        chk("mid_rst_overflow", 32'(o_overflow), 0);
        chk("mid_rst_drop_count", 32'(o_drop_count), 0);
        chk("mid_rst_line_count", 32'(o_line_count), 0);
        mon_en = 1'b1;
        snap = out_cnt;
        for (int r = 0; r < 2; r++) begin
            fill_bytes(32);
            send_line(32);
        end
        chk("no_frame_no_output", 32'(out_cnt - snap), 0);

        // Latency from second byte to o_valid, then the padded remainder
        vsync_pulse();
        fill_bytes(2);
        push_exp(2, 0, COLS);
        i_href = 1'b1;
        i_data = line_bytes[0];
        tick(1);
        i_data = line_bytes[1];
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            tick(1);
            if (n == 1) begin
                i_href = 1'b0;
                i_data = 8'd0;
            end
            if (o_valid && lat == 0) lat = n;
        end
        chk("latency", 32'(lat), 3);

        for (int n = 0; n < 100 && exp_q.size() > 0; n++) begin
            tick(1);
            drain_obs();
        end
        chk("final_drained", 32'(exp_q.size()), 0);
        chk("final_line_count", 32'(o_line_count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
